// File: rtl/truth_table_capture_pkg.sv
// rtl/truth_table_capture_pkg.sv - shared state encodings and counter width for the truth-table capture block
package truth_table_capture_pkg;

  typedef enum logic [2:0] {
    TT_IDLE   = 3'd0,
    TT_WAIT   = 3'd1,
    TT_SETTLE = 3'd2,
    TT_CHECK  = 3'd3,
    TT_DONE   = 3'd4
  } tt_state_e;

  localparam int TT_CNT_W = 8;

endpackage

// File: rtl/truth_table_capture_if.sv
// rtl/truth_table_capture_if.sv - input-vector handshake between the stimulus source and the capture block
interface truth_table_capture_if #(
  parameter int N_IN = 3
);

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_out;

  modport master (
    output in_valid,
    output in_vec,
    output in_out,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  in_out,
    output in_ready
  );

endinterface

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable down-counter that flags when the settle window has elapsed
module tt_settle_timer
  import truth_table_capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic                i_dec,
  input  logic [TT_CNT_W-1:0] i_load_val,
  output logic                o_zero
);

  logic [TT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - captures a truth table row per handshake and checks it against a golden table
// Optional conflict detection is built when TT_CAPTURE_CONFLICT_EN is defined.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int                    N_IN       = 3,
  parameter int                    SETTLE_CYC = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED   = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  truth_table_capture_if.slave bus,
  output logic [(1<<N_IN)-1:0] table_q,
  output logic [(1<<N_IN)-1:0] cov_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic                 conflict
);

  localparam int                  W         = 1 << N_IN;
  localparam logic [TT_CNT_W-1:0] SETTLE_LD = TT_CNT_W'(SETTLE_CYC);

  tt_state_e       r_state;
  logic [N_IN-1:0] r_idx;
  logic [W-1:0]    r_table;
  logic [W-1:0]    r_cov;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_mismatch;

  logic            w_accept;
  logic            w_zero;
  logic            w_sample;
  logic [W-1:0]    w_row;
  logic [W-1:0]    w_cov_next;

  assign w_accept   = (r_state == TT_WAIT) && bus.in_valid && r_in_ready;
  assign w_sample   = (r_state == TT_SETTLE) && w_zero;
  assign w_row      = {{(W-1){1'b0}}, 1'b1} << r_idx;
  assign w_cov_next = r_cov | w_row;

  tt_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept && !start),
    .i_dec      (r_state == TT_SETTLE),
    .i_load_val (SETTLE_LD),
    .o_zero     (w_zero)
  );

  // start outranks every other event, so it is checked ahead of the state case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TT_IDLE;
      r_idx      <= '0;
      r_table    <= '0;
      r_cov      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (start) begin
      r_state    <= TT_WAIT;
      r_table    <= '0;
      r_cov      <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        TT_WAIT: begin
          if (w_accept) begin
            r_idx      <= bus.in_vec;
            r_in_ready <= 1'b0;
            r_state    <= TT_SETTLE;
          end
        end
        TT_SETTLE: begin
          if (w_zero) begin
            r_table[r_idx] <= bus.in_out;
            r_cov          <= w_cov_next;
            // Completion depends on which rows are covered, not on how many samples arrived.
            if (&w_cov_next) begin
              r_state <= TT_CHECK;
            end else begin
              r_state    <= TT_WAIT;
              r_in_ready <= 1'b1;
            end
          end
        end
        TT_CHECK: begin
          r_mismatch <= (r_table != EXPECTED);
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= TT_DONE;
        end
        TT_DONE: begin
          r_state <= TT_DONE;
        end
        default: begin
          r_state <= TT_IDLE;
        end
      endcase
    end
  end

`ifdef TT_CAPTURE_CONFLICT_EN
  logic r_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else if (start) begin
      r_conflict <= 1'b0;
    end else if (w_sample && r_cov[r_idx] && (bus.in_out != r_table[r_idx])) begin
      r_conflict <= 1'b1;
    end
  end

  assign conflict = r_conflict;
`else
  assign conflict = 1'b0;
`endif

  assign bus.in_ready = r_in_ready;
  assign table_q      = r_table;
  assign cov_mask     = r_cov;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mismatch     = r_mismatch;

endmodule

// File: tb/tb_truth_table_capture.sv
// tb/tb_truth_table_capture.sv - directed/randomized bench with a row-level reference model for truth_table_capture
module tb_truth_table_capture;

  localparam int SETTLE = 2;
`ifdef TT_CAPTURE_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] table_q;
  logic [7:0] cov_mask;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  bit m_tab [8];
  bit m_cov [8];
  bit m_conf;

  truth_table_capture_if #(.N_IN(3)) tt_if ();

  truth_table_capture #(
    .N_IN       (3),
    .SETTLE_CYC (SETTLE),
    .EXPECTED   (8'hE8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (tt_if),
    .table_q  (table_q),
    .cov_mask (cov_mask),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic bit maj(input int i);
    return (((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)) >= 2;
  endfunction

  function automatic logic [7:0] model_vec(input bit useCov);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = useCov ? m_cov[i] : m_tab[i];
    return r;
  endfunction

  function automatic logic [7:0] golden();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = maj(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_tab[i] = 1'b0;
      m_cov[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    check("start_cov_cleared", cov_mask, 8'h00);
    check("start_table_cleared", table_q, 8'h00);
    check("start_busy", busy, 1);
    check("start_ready", tt_if.in_ready, 1);
    check("start_done_low", done, 0);
    check("start_conflict_low", conflict, 0);
  endtask

  task automatic send(input int v, input bit o);
    int n;
    bit full;
    n = 0;
    while (tt_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_send", tt_if.in_ready, 1);
    tt_if.in_valid = 1'b1;
    tt_if.in_vec   = v[2:0];
    tt_if.in_out   = ~o;
    @(posedge clk); #1;
    for (int k = 0; k <= SETTLE; k++) begin
      check("ready_low_in_settle", tt_if.in_ready, 0);
      tt_if.in_valid = 1'($urandom_range(1, 0));
      if (k == SETTLE) tt_if.in_out = o;
      @(posedge clk); #1;
    end
    tt_if.in_valid = 1'b0;
    if (CONF_EN && m_cov[v] && (m_tab[v] != o)) m_conf = 1'b1;
    m_tab[v] = o;
    m_cov[v] = 1'b1;
    check("table_after_sample", table_q, model_vec(0));
    check("cov_after_sample", cov_mask, model_vec(1));
    check("conflict_after_sample", conflict, m_conf);
    full = (model_vec(1) == 8'hFF);
    if (full) begin
      check("check_state_busy", busy, 1);
      check("check_state_not_done", done, 0);
      @(posedge clk); #1;
      check("done_set", done, 1);
      check("done_busy_low", busy, 0);
      check("mismatch_result", mismatch, model_vec(0) != golden());
    end else begin
      check("ready_back_in_wait", tt_if.in_ready, 1);
      check("not_done_partial", done, 0);
    end
  endtask

  task automatic shuffle8(output int ord [8]);
    int j, t;
    for (int i = 0; i < 8; i++) ord[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
  endtask

  initial begin
    int ord [8];
    int dup [8];
    rst_n          = 1'b0;
    start          = 1'b0;
    tt_if.in_valid = 1'b0;
    tt_if.in_vec   = '0;
    tt_if.in_out   = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_table", table_q, 0);
    check("reset_cov", cov_mask, 0);
    check("reset_ready", tt_if.in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mismatch", mismatch, 0);
    check("reset_conflict", conflict, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready_low", tt_if.in_ready, 0);

    // Majority sweep in random order
    do_start();
    shuffle8(ord);
    for (int i = 0; i < 8; i++) send(ord[i], maj(ord[i]));
    check("sweep1_table", table_q, 8'hE8);
    check("sweep1_cov", cov_mask, 8'hFF);
    check("sweep1_mismatch", mismatch, 0);
    for (int i = 0; i < 4; i++) begin
      tt_if.in_valid = 1'b1;
      tt_if.in_vec   = 3'($urandom_range(7, 0));
      tt_if.in_out   = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    tt_if.in_valid = 1'b0;
    check("done_held", done, 1);
    check("done_table_frozen", table_q, 8'hE8);
    check("done_ready_low", tt_if.in_ready, 0);

    // Row 0 forced to 1
    do_start();
    shuffle8(ord);
    for (int i = 0; i < 8; i++) send(ord[i], (ord[i] == 0) ? 1'b1 : maj(ord[i]));
    check("sweep2_table", table_q, 8'hE9);
    check("sweep2_done", done, 1);
    check("sweep2_mismatch", mismatch, 1);

    // Repeats do not complete the table
    do_start();
    shuffle8(ord);
    for (int i = 0; i < 8; i++) dup[i] = (ord[i] == 7) ? 3 : ord[i];
    for (int i = 0; i < 8; i++) send(dup[i], maj(dup[i]));
    check("dup_cov", cov_mask, 8'h7F);
    check("dup_not_done", done, 0);
    send(7, maj(7));
    check("dup_then_7_done", done, 1);
    check("dup_then_7_mismatch", mismatch, 0);

    // Row 5 resampled with a different value
    do_start();
    send(5, 1'b1);
    send(5, 1'b0);
    check("row5_zero", table_q[5], 0);
    check("row5_conflict", conflict, CONF_EN);
    shuffle8(ord);
    for (int i = 0; i < 8; i++)
      if (ord[i] != 5) send(ord[i], 1'($urandom_range(1, 0)));
    check("rand_done", done, 1);
    check("conflict_sticky", conflict, CONF_EN);

    // Asynchronous reset during SETTLE
    do_start();
    shuffle8(ord);
    for (int i = 0; i < 4; i++) send(ord[i], maj(ord[i]));
    tt_if.in_valid = 1'b1;
    tt_if.in_vec   = ord[4][2:0];
    tt_if.in_out   = 1'b1;
    @(posedge clk); #1;
    tt_if.in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_table", table_q, 0);
    check("abort_cov", cov_mask, 0);
    check("abort_ready", tt_if.in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mismatch", mismatch, 0);
    check("abort_conflict", conflict, 0);
    #2 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    check("post_reset_idle_ready", tt_if.in_ready, 0);
    check("post_reset_idle_busy", busy, 0);

    // start mid-sweep, then start during SETTLE
    do_start();
    for (int i = 0; i < 3; i++) send(ord[i], maj(ord[i]));
    check("mid_cov_nonzero", cov_mask != 0, 1);
    do_start();
    tt_if.in_valid = 1'b1;
    tt_if.in_vec   = 3'd6;
    @(posedge clk); #1;
    tt_if.in_valid = 1'b0;
    do_start();
    repeat (SETTLE + 2) @(posedge clk);
    #1;
    check("restart_in_settle_cov", cov_mask, 0);
    check("restart_in_settle_ready", tt_if.in_ready, 1);
    shuffle8(ord);
    for (int i = 0; i < 8; i++) send(ord[i], maj(ord[i]));
    check("final_table", table_q, 8'hE8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
